// File: rtl/clk_div_bank_pkg.sv
// Purpose : shared types and helpers for the clk_div_bank divided-clock generator.
// Latency : n/a (package only; functions are purely combinational).
// Backpr. : n/a.
// Contents: state_e {SETTLE, LOCKED}; clamp_div, clamp_phase, hi_len operate on
//           32-bit values so any CNT_WIDTH up to 32 can use them via casts.
package clk_div_bank_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // A divide ratio below 2 cannot produce a clock, so it is forced up to 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  // A start count outside [0, div-1] would never be reached by the counter.
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                              input logic [31:0] div);
    return (phase >= div) ? 32'd0 : phase;
  endfunction

  // High portion of the period: ceil(div/2), so odd ratios are high one cycle longer.
  function automatic logic [31:0] hi_len(input logic [31:0] div);
    return (div >> 1) + {31'd0, div[0]};
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// Purpose : one divider channel: counter plus div/phase registers, registered outclk/outclk_en.
// Latency : outputs are computed from the next counter value in the same register stage (0 cycles).
// Backpr. : none; restart/run come from the top-level FSM every cycle.
// Ports   : clk, reset_n (async active-low); cfg_load with raw cfg_div/cfg_phase (clamped here);
//           restart (hold counter at start count, outputs low); run (advance counter);
//           outclk, outclk_en (registered).
module clk_div_channel #(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned DEFAULT_DIV   = 2,
  parameter int unsigned DEFAULT_PHASE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_load,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic [CNT_WIDTH-1:0] cfg_phase,
  input  logic                 restart,
  input  logic                 run,
  output logic                 outclk,
  output logic                 outclk_en
);
  import clk_div_bank_pkg::*;

  localparam logic [CNT_WIDTH-1:0] RST_DIV   = CNT_WIDTH'(clamp_div(32'(DEFAULT_DIV)));
  localparam logic [CNT_WIDTH-1:0] RST_PHASE =
    CNT_WIDTH'(clamp_phase(32'(DEFAULT_PHASE), 32'(RST_DIV)));

  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 outclk_q, outclk_d;
  logic                 outclk_en_q, outclk_en_d;
  logic [CNT_WIDTH:0]   cnt_inc;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (cfg_load) begin
      div_d   = CNT_WIDTH'(clamp_div(32'(cfg_div)));
      phase_d = CNT_WIDTH'(clamp_phase(32'(cfg_phase), 32'(div_d)));
    end

    // One extra bit so the wrap compare is safe at the largest ratio.
    cnt_inc = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

    // When not running the counter sits at the start count; the first
    // non-restart, non-run cycle (entering LOCKED) therefore outputs phase.
    if (run) begin
      cnt_d = (cnt_inc >= {1'b0, div_q}) ? '0 : cnt_inc[CNT_WIDTH-1:0];
    end else begin
      cnt_d = phase_d;
    end

    outclk_d    = !restart && (32'(cnt_d) < hi_len(32'(div_d)));
    outclk_en_d = !restart && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= RST_DIV;
      phase_q     <= RST_PHASE;
      cnt_q       <= RST_PHASE;
      outclk_q    <= 1'b0;
      outclk_en_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      outclk_q    <= outclk_d;
      outclk_en_q <= outclk_en_d;
    end
  end

  assign outclk    = outclk_q;
  assign outclk_en = outclk_en_q;

endmodule

// File: rtl/clk_div_bank.sv
// Purpose : NUM_CLOCKS phase-aligned divided clocks + enable strobes with a PLL-style locked flag.
// Latency : locked rises LOCK_CYCLES edges after reset release or an accepted write.
// Backpr. : cfg_waitrequest is high while settling; a held write is taken once locked.
// Ports   : clk, reset_n (async active-low); cfg_write/cfg_channel/cfg_div/cfg_phase write port;
//           cfg_waitrequest; outclk, outclk_en, locked (all registered except waitrequest).
// Config  : CLK_DIV_BANK_RECONFIG_EN enables the write port; without it the cfg_* inputs are
//           ignored, cfg_waitrequest is 0 and every channel runs at its clamped defaults.
module clk_div_bank #(
  parameter int unsigned NUM_CLOCKS    = 2,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned DEFAULT_DIV   = 2,
  parameter int unsigned DEFAULT_PHASE = 0,
  parameter int unsigned LOCK_CYCLES   = 16
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic                                                cfg_write,
  input  logic [((NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1)-1:0] cfg_channel,
  input  logic [CNT_WIDTH-1:0]                                cfg_div,
  input  logic [CNT_WIDTH-1:0]                                cfg_phase,
  output logic                                                cfg_waitrequest,
  output logic [NUM_CLOCKS-1:0]                               outclk,
  output logic [NUM_CLOCKS-1:0]                               outclk_en,
  output logic                                                locked
);
  import clk_div_bank_pkg::*;

  localparam int unsigned SETTLE_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);

  state_e                state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  locked_q, locked_d;
  logic                  write_acc;
  logic                  ch_restart;
  logic                  ch_run;
  logic [NUM_CLOCKS-1:0] ch_load;

`ifdef CLK_DIV_BANK_RECONFIG_EN
  assign cfg_waitrequest = (state_q == SETTLE);
  // Out-of-range channels are silently dropped and do not restart the bank.
  assign write_acc = cfg_write && !cfg_waitrequest && (32'(cfg_channel) < NUM_CLOCKS);
`else
  logic unused_cfg_write;
  assign unused_cfg_write = cfg_write;
  assign cfg_waitrequest  = 1'b0;
  assign write_acc        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      locked_q     <= locked_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = LOCKED;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (write_acc) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
        end
      end
      default: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  // Output / channel-control logic. Every channel shares restart/run so all
  // counters restart on the same edge and keep their relative phases.
  always_comb begin
    locked_d   = (state_d == LOCKED);
    ch_restart = (state_d == SETTLE);
    ch_run     = (state_q == LOCKED) && (state_d == LOCKED);
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    assign ch_load[i] = write_acc && (32'(cfg_channel) == 32'(i));

    clk_div_channel #(
      .CNT_WIDTH    (CNT_WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_PHASE(DEFAULT_PHASE)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .cfg_load (ch_load[i]),
      .cfg_div  (cfg_div),
      .cfg_phase(cfg_phase),
      .restart  (ch_restart),
      .run      (ch_run),
      .outclk   (outclk[i]),
      .outclk_en(outclk_en[i])
    );
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Purpose : self-checking bench for clk_div_bank against a per-cycle arithmetic reference model.
// Latency : n/a.
// Backpr. : n/a; writes are dropped by the bench after one cycle whether accepted or not.
module tb_clk_div_bank;

  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int DDIV = 4;
  localparam int DPH  = 0;
  localparam int LOCK = 16;

`ifdef CLK_DIV_BANK_RECONFIG_EN
  localparam bit RECONFIG = 1'b1;
`else
  localparam bit RECONFIG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cfg_write;
  logic [1:0]     cfg_channel;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_phase;
  logic           cfg_waitrequest;
  logic [NCH-1:0] outclk;
  logic [NCH-1:0] outclk_en;
  logic           locked;

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel ratio/start count and the edge at which
  // the bank (re)locks. Edge numbers count rising edges since reset release.
  int m_div   [NCH];
  int m_phase [NCH];
  int edge_n;
  int lock_edge;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CLOCKS   (NCH),
    .CNT_WIDTH    (CW),
    .DEFAULT_DIV  (DDIV),
    .DEFAULT_PHASE(DPH),
    .LOCK_CYCLES  (LOCK)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_write      (cfg_write),
    .cfg_channel    (cfg_channel),
    .cfg_div        (cfg_div),
    .cfg_phase      (cfg_phase),
    .cfg_waitrequest(cfg_waitrequest),
    .outclk         (outclk),
    .outclk_en      (outclk_en),
    .locked         (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]   = DDIV;
      m_phase[i] = DPH;
    end
    edge_n    = 0;
    lock_edge = LOCK;
  endtask

  // Expected outputs after edge edge_n: position in the period is simply
  // (start count + edges since lock) mod ratio.
  task automatic check_cycle();
    logic [NCH-1:0] eo;
    logic [NCH-1:0] ee;
    logic           el;
    int             k;
    int             pos;
    el = (edge_n >= lock_edge);
    eo = '0;
    ee = '0;
    if (el) begin
      k = edge_n - lock_edge;
      for (int i = 0; i < NCH; i++) begin
        pos   = (m_phase[i] + k) % m_div[i];
        eo[i] = (pos < (m_div[i] + 1) / 2);
        ee[i] = (pos == 0);
      end
    end
    chk("outclk", 32'(outclk), 32'(eo));
    chk("outclk_en", 32'(outclk_en), 32'(ee));
    chk("locked", 32'(locked), 32'(el));
    chk("waitrequest", 32'(cfg_waitrequest), 32'(RECONFIG && !el));
  endtask

  // One rising edge with whatever inputs are currently driven, then check.
  task automatic step();
    bit acc;
    int ch;
    int d;
    int p;
    acc = RECONFIG && cfg_write && (edge_n >= lock_edge) && (int'(cfg_channel) < NCH);
    ch  = int'(cfg_channel);
    d   = int'(cfg_div);
    p   = int'(cfg_phase);
    @(posedge clk);
    edge_n++;
    if (acc) begin
      m_div[ch]   = (d < 2) ? 2 : d;
      m_phase[ch] = (p >= m_div[ch]) ? 0 : p;
      lock_edge   = edge_n + LOCK;
    end
    #1;
    check_cycle();
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [CW-1:0] d, input logic [CW-1:0] p);
    cfg_write   = 1'b1;
    cfg_channel = ch;
    cfg_div     = d;
    cfg_phase   = p;
    step();
    cfg_write   = 1'b0;
  endtask

  initial begin
    logic [7:0] pat_clk;
    logic [7:0] pat_en;

    reset_n     = 1'b0;
    cfg_write   = 1'b0;
    cfg_channel = '0;
    cfg_div     = '0;
    cfg_phase   = '0;
    model_defaults();

    // Reset values.
    #12;
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_outclk_en", 32'(outclk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_waitrequest", 32'(cfg_waitrequest), 32'(RECONFIG));

    @(negedge clk);
    reset_n = 1'b1;
    model_defaults();

    // Settle then lock at edge LOCK; also compare ch0 against the literal
    // divide-by-4 pattern for the first 8 locked cycles.
    repeat (LOCK - 1) step();
    chk("pre_lock", 32'(locked), 32'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      pat_clk[7 - c] = outclk[0];
      pat_en[7 - c]  = outclk_en[0];
    end
    chk("div4_pattern", 32'(pat_clk), 32'h0000_00CC);
    chk("div4_strobes", 32'(pat_en), 32'h0000_0088);

    // Directed writes.
    do_write(2'd1, 8'd5, 8'd2);
    do_write(2'd0, 8'd3, 8'd1);            // during settle: ignored
    repeat (3) step();
    do_write(2'd2, 8'd9, 8'd0);            // during settle: ignored
    repeat (LOCK + 12) step();
    do_write(2'd0, 8'd0, 8'd0);            // div 0 -> 2
    repeat (LOCK + 8) step();
    do_write(2'd2, 8'd1, 8'd0);            // div 1 -> 2
    repeat (LOCK + 8) step();
    do_write(2'd2, 8'd4, 8'd7);            // phase 7 >= 4 -> 0
    repeat (LOCK + 8) step();
    do_write(2'd3, 8'd6, 8'd1);            // out-of-range channel: no restart
    repeat (10) step();
    do_write(2'd1, 8'd7, 8'd6);            // largest legal phase
    repeat (LOCK + 10) step();

    // Randomised writes, some landing in the settle window.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 24)) step();
      do_write(2'($urandom_range(0, 3)), CW'($urandom_range(0, 12)), CW'($urandom_range(0, 12)));
    end
    repeat (LOCK + 10) step();

    // Asynchronous reset mid-run: outputs drop without a clock edge.
    @(posedge clk);
    edge_n++;
    #1;
    check_cycle();
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_outclk", 32'(outclk), 32'd0);
    chk("arst_outclk_en", 32'(outclk_en), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_waitrequest", 32'(cfg_waitrequest), 32'(RECONFIG));
    @(negedge clk);
    reset_n = 1'b1;
    model_defaults();
    repeat (LOCK + 20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable/divided-clock generator for the system clock domain: it produces up to NUM_CLOCKS phase-aligned divided clocks and single-cycle enable strobes from one fabric clock. Unlike the fixed two-output system PLL, ratios and phase offsets are runtime-reprogrammable through a write port with a synchronised restart. A PLL-style `locked` flag signals that the outputs are valid. It sits downstream of the system PLL and feeds low-rate peripherals (audio, PS/2, timers).

## Interface
- NUM_CLOCKS, 2: number of output channels (1..16)
- CNT_WIDTH, 16: divider/phase counter width
- DEFAULT_DIV, 2: divide ratio of every channel after reset
- DEFAULT_PHASE, 0: start count of every channel after reset
- LOCK_CYCLES, 16: settle length in clk cycles (≥1)

- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_write  in  1  write request
- cfg_channel  in  $clog2(NUM_CLOCKS) (min 1)  target channel
- cfg_div  in  CNT_WIDTH  new divide ratio
- cfg_phase  in  CNT_WIDTH  new start count
- cfg_waitrequest  out  1  high = write not accepted
- outclk  out  NUM_CLOCKS  divided clocks, registered
- outclk_en  out  NUM_CLOCKS  one-cycle strobe at each outclk rising point, registered
- locked  out  1  outputs valid

## Operation
- FSM: SETTLE, LOCKED. Reset → SETTLE, settle counter 0.
- SETTLE: channel counters held at start count; outclk=0, outclk_en=0, locked=0; settle counter increments; at count LOCK_CYCLES-1 → LOCKED.
- Edge entering LOCKED: every cnt_i=phase_i, outclk_i=(phase_i<hi_i), outclk_en_i=(phase_i==0), locked=1. Each subsequent edge cnt_i=(cnt_i+1) mod div_i, outputs recomputed from new cnt_i.
- hi_i = (div_i+1)>>1 (div 3 → high 2, low 1).
- Write accepted when cfg_write && !cfg_waitrequest && cfg_channel<NUM_CLOCKS: div/phase of that channel updated, FSM → SETTLE, all channels restart together (phase relations preserved).
- Clamping at write: cfg_div<2 stored as 2; cfg_phase≥stored div stored as 0.
- cfg_channel≥NUM_CLOCKS: write dropped, no restart, no error.
- cfg_waitrequest = (state==SETTLE).
- reset_n low at any time: immediate return to reset values; div/phase revert to defaults.

## Timing
- Reset values: outclk=0, outclk_en=0, locked=0, cfg_waitrequest=1.
- locked rises on the LOCK_CYCLES-th rising edge after reset_n deassertion.
- Write accepted at edge E: at E outputs/locked go 0, waitrequest 1; locked rises at edge E+LOCK_CYCLES.
- cfg_write during SETTLE: ignored (waitrequest high); requester holds.
- Strobe and outclk rise coincide; latency counter→output 0 cycles (same register stage).

## Configuration
- CLK_DIV_BANK_RECONFIG_EN defined: config port functional as above.
- Undefined: cfg_* inputs ignored, cfg_waitrequest tied 0, div/phase fixed at DEFAULT_DIV/DEFAULT_PHASE (clamped); reset/settle/locked behaviour unchanged.

## Structure
- clk_div_bank_pkg: state enum {SETTLE, LOCKED}, clamp_div/clamp_phase functions, hi-length function.
- Sub-module clk_div_channel: one counter, div/phase registers, outclk/outclk_en outputs; restart and run inputs from the top-level FSM; instantiated NUM_CLOCKS times via generate.

## Test plan
- Reset release, DEFAULT_DIV=4, LOCK_CYCLES=16 → locked rises at edge 16; outclk 1,1,0,0 repeating; outclk_en on cycles 0,4,8.
- Write ch1 div=5 phase=2 → 16 cycles outputs 0, waitrequest 1; then ch1 outclk 1,0,0,1,1 repeating, ch0 restarts 1,1,0,0.
- Write div=0 then div=1 → each stored as 2; outclk 1,0 toggling, strobe every 2nd cycle.
- Write div=4 phase=7 → phase 0; cfg_channel=NUM_CLOCKS → no restart, locked stays 1.
- reset_n pulsed low mid-run → outputs 0 same cycle, defaults restored, relock after 16 edges.
- Macro undefined: writes ignored, cfg_waitrequest=0, outputs follow defaults without interruption.
